mdr_arbiter: RTL and testbench

Round-robin scheduler that shares one iterative multiply/divide/square-root datapath among four requesters. It captures the winning request's operands, issues a start to the datapath, and waits for completion or timeout. It then drives the select and gated data of the 1-to-4 result demux so the result reaches only the granted requester. The block sits between the four requester ports and the shared MDR core, inside the MDR subsystem.

---
 rtl/mdr_pkg.sv | 24 ++
 rtl/mdr_arbiter_rr_pick4.sv | 27 ++
 rtl/mdr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mdr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared types and widths for the MDR subsystem
// Exports: DW, DW_DBL, N_REQ, mdr_op_t, mdr_arb_state_t.
package mdr_pkg;

  localparam int DW     = 16;
  localparam int DW_DBL = 2*DW-1;
  localparam int N_REQ  = 4;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSV  = 2'b11
  } mdr_op_t;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_LOAD    = 3'd1,
    ARB_WAIT    = 3'd2,
    ARB_DELIVER = 3'd3,
    ARB_ABORT   = 3'd4
  } mdr_arb_state_t;

endpackage

// File: rtl/mdr_arbiter_rr_pick4.sv
// rtl/mdr_arbiter_rr_pick4.sv - combinational 4-way round-robin picker
// Ports: req[3:0] requests, ptr[1:0] search start,
//        idx[1:0] first asserted index at or after ptr (mod 4), any = some req high.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    idx  = 2'd0;
    any  = 1'b0;
    cand = 2'd0;
    // Walk upward from ptr; the 2-bit add wraps naturally mod 4.
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdr_arbiter.sv
// rtl/mdr_arbiter.sv - round-robin scheduler for the shared MDR datapath
// Ports: clk, rst (async active-low); req/req_op/req_a/req_b from four requesters;
//        grant/ack/err back to requesters; dp_start/dp_op/dp_a/dp_b/dp_done/dp_result
//        to the shared core; demux_sel/demux_data to the result demux; busy.
module mdr_arbiter
  import mdr_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0][1:0]  req_op,
  input  logic [N_REQ-1:0][DW-1:0] req_a,
  input  logic [N_REQ-1:0][DW-1:0] req_b,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   dp_start,
  output logic [1:0]             dp_op,
  output logic [DW-1:0]          dp_a,
  output logic [DW-1:0]          dp_b,
  input  logic                   dp_done,
  input  logic [DW_DBL:0]        dp_result,
  output logic [1:0]             demux_sel,
  output logic [DW_DBL:0]        demux_data,
  output logic                   busy
);

  localparam logic [2:0] S_IDLE    = ARB_IDLE;
  localparam logic [2:0] S_LOAD    = ARB_LOAD;
  localparam logic [2:0] S_WAIT    = ARB_WAIT;
  localparam logic [2:0] S_DELIVER = ARB_DELIVER;
  localparam logic [2:0] S_ABORT   = ARB_ABORT;

  // Last WAIT count before giving up; WAIT therefore lasts TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW_DBL:0] res_q, res_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;

  logic [1:0]      pick_idx;
  logic            pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          op_d    = req_op[pick_idx];
          a_d     = req_a[pick_idx];
          b_d     = req_b[pick_idx];
          // Reserved opcode never reaches the datapath.
          state_d = (req_op[pick_idx] == OP_RSV) ? S_ABORT : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Completion takes priority over a coincident timeout.
        if (dp_done) begin
          res_d   = dp_result;
          state_d = S_DELIVER;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_DELIVER, S_ABORT: begin
        rr_ptr_d = idx_q + 2'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      op_q     <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= 8'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs are decoded from registered state only.
  logic       in_grant;
  logic       in_resp;
  logic [3:0] idx_onehot;

  always_comb begin
    in_grant   = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                 (state_q == S_DELIVER) || (state_q == S_ABORT);
    in_resp    = (state_q == S_DELIVER) || (state_q == S_ABORT);
    idx_onehot = 4'd1 << idx_q;
    grant      = in_grant ? idx_onehot : 4'd0;
    ack        = in_resp ? idx_onehot : 4'd0;
    err        = (state_q == S_ABORT);
    dp_start   = (state_q == S_LOAD);
    dp_op      = op_q;
    dp_a       = a_q;
    dp_b       = b_q;
    demux_sel  = in_resp ? idx_q : 2'd0;
    demux_data = (state_q == S_DELIVER) ? res_q : '0;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mdr_arbiter.sv
// tb/tb_mdr_arbiter.sv - directed self-checking bench for mdr_arbiter
module tb_mdr_arbiter;
  import mdr_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [3:0]               req = 4'd0;
  logic [3:0][1:0]          req_op = '0;
  logic [3:0][DW-1:0]       req_a;
  logic [3:0][DW-1:0]       req_b;
  logic [3:0]               grant;
  logic [3:0]               ack;
  logic                     err;
  logic                     dp_start;
  logic [1:0]               dp_op;
  logic [DW-1:0]            dp_a;
  logic [DW-1:0]            dp_b;
  logic                     dp_done = 1'b0;
  logic [DW_DBL:0]          dp_result = '0;
  logic [1:0]               demux_sel;
  logic [DW_DBL:0]          demux_data;
  logic                     busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mdr_arbiter #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .grant      (grant),
    .ack        (ack),
    .err        (err),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_done    (dp_done),
    .dp_result  (dp_result),
    .demux_sel  (demux_sel),
    .demux_data (demux_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the LOAD cycle.
  task automatic wait_start(input string tag, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (dp_start) seen = 1'b1;
    end
    if (!seen) check({tag, "_start_wait"}, 64'd0, 64'd1);
  endtask

  // One complete service: expect idx to be granted, finish after dly WAIT cycles.
  task automatic serve(input string tag, input logic [1:0] idx, input logic [31:0] res,
                       input int dly, input logic drop, input logic [3:0] req_after);
    logic seen;
    logic [3:0] oh;
    oh = 4'd1 << idx;
    wait_start(tag, seen);
    if (!seen) return;
    check({tag, "_grant"}, grant, oh);
    check({tag, "_dp_a"}, dp_a, req_a[idx]);
    for (int i = 0; i < dly; i++) begin
      tick();
      if (drop && i == 0) req[idx] = 1'b0;
    end
    dp_done   = 1'b1;
    dp_result = res;
    tick();
    dp_done   = 1'b0;
    dp_result = '0;
    check({tag, "_ack"}, ack, oh);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_sel"}, demux_sel, idx);
    check({tag, "_data"}, demux_data, res);
    req = req_after;
    tick();
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_ack_clr"}, ack, 4'd0);
  endtask

  initial begin
    logic seen;
    int k;
    req_a = {16'h0013, 16'h0003, 16'h0011, 16'h0010};
    req_b = {16'h0023, 16'h0005, 16'h0021, 16'h0020};

    // Reset values
    tick();
    tick();
    check("rst_grant", grant, 4'd0);
    check("rst_ack", ack, 4'd0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", dp_start, 1'b0);
    check("rst_data", demux_data, 32'd0);
    check("rst_dp_a", dp_a, 16'd0);
    rst = 1'b1;
    tick();

    // Single request: MUL 3*5, done 4 cycles after start
    req_op[2] = OP_MUL;
    req = 4'b0100;
    wait_start("single", seen);
    check("single_grant", grant, 4'b0100);
    check("single_op", dp_op, 2'b00);
    check("single_b", dp_b, 16'd5);
    tick();
    check("single_start_1cyc", dp_start, 1'b0);
    tick(); tick(); tick();
    dp_done = 1'b1; dp_result = 32'd15;
    tick();
    dp_done = 1'b0; dp_result = '0;
    check("single_ack", ack, 4'b0100);
    check("single_err", err, 1'b0);
    check("single_sel", demux_sel, 2'd2);
    check("single_data", demux_data, 32'd15);
    req = 4'b0000;
    tick();
    check("single_ack_pulse", ack, 4'd0);
    check("single_data_clr", demux_data, 32'd0);

    // Fairness: all requesters held from reset
    rst = 1'b0;
    req = 4'b1111;
    tick(); tick();
    rst = 1'b1;
    serve("rr0", 2'd0, 32'h100, 1, 1'b0, 4'b1111);
    serve("rr1", 2'd1, 32'h101, 1, 1'b0, 4'b1111);
    serve("rr2", 2'd2, 32'h102, 1, 1'b0, 4'b1111);
    serve("rr3", 2'd3, 32'h103, 1, 1'b0, 4'b1111);
    serve("rr0b", 2'd0, 32'h104, 1, 1'b0, 4'b1111);
    serve("rr1b", 2'd1, 32'h105, 1, 1'b0, 4'b1111);
    serve("rr2b", 2'd2, 32'h106, 1, 1'b0, 4'b1111);
    serve("rr3b", 2'd3, 32'h107, 1, 1'b0, 4'b0010);
    serve("rr_only1", 2'd1, 32'h108, 1, 1'b0, 4'b0000);

    // Timeout: no dp_done, abort 8 cycles after WAIT entry
    req = 4'b0001;
    wait_start("tmo", seen);
    tick();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack != 4'd0) break;
      tick();
      k++;
    end
    check("tmo_cycles", k, 8);
    check("tmo_ack", ack, 4'b0001);
    check("tmo_err", err, 1'b1);
    check("tmo_data", demux_data, 32'd0);
    check("tmo_grant", grant, 4'b0001);
    req = 4'b0000;
    tick();
    check("tmo_idle", busy, 1'b0);

    // dp_done on the timeout cycle wins
    req = 4'b0100;
    serve("tie", 2'd2, 32'hABCD1234, 8, 1'b0, 4'b0000);

    // Request dropped during WAIT is still served
    req = 4'b1000;
    serve("drop", 2'd3, 32'h55, 3, 1'b1, 4'b0000);

    // Reserved opcode on requester 1
    req_op[1] = OP_RSV;
    req = 4'b0010;
    tick();
    check("rsv_start", dp_start, 1'b0);
    check("rsv_ack", ack, 4'b0010);
    check("rsv_err", err, 1'b1);
    check("rsv_grant", grant, 4'b0010);
    check("rsv_sel", demux_sel, 2'd1);
    check("rsv_data", demux_data, 32'd0);
    req = 4'b0000;
    req_op[1] = OP_MUL;
    tick();
    check("rsv_idle", busy, 1'b0);

    // Reset during WAIT, then re-arbitrate from pointer 0
    req = 4'b1000;
    wait_start("rstw", seen);
    tick(); tick();
    check("rstw_in_wait", grant, 4'b1000);
    #2 rst = 1'b0;
    #1;
    check("rstw_grant", grant, 4'd0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_dp_a", dp_a, 16'd0);
    check("rstw_ack", ack, 4'd0);
    req = 4'b1010;
    tick();
    check("rstw_no_ack", ack, 4'd0);
    rst = 1'b1;
    serve("rstw_after", 2'd1, 32'h77, 1, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
